lane_deskew: RTL and testbench
==============================

Name: lane_deskew

Overview:
- Multi-lane receive deskew stage after the per-lane 10b/8b decoders, in the RxBitCLK_10 symbol domain.
- Generalises the single-lane Rx symbol path (RxParallel_8 / RxDataK) to LANES lanes.
- Buffers each lane in a small FIFO and aligns all lanes on a common COM symbol (K28.5).
- Presents one word-aligned symbol per lane per cycle, with alignment status and error pulses.

Parameters:
LANES, 4, number of Rx lanes (1..8)
DEPTH, 8, per-lane FIFO depth in symbols (power of 2, >= 4)
MAX_SKEW, 5, maximum inter-lane skew in symbol cycles tolerated during search (< DEPTH)
COM, 8'hBC, data byte that marks an alignment symbol when its K flag is 1

Ports:
RxBitCLK_10  input  1  symbol clock; all logic on rising edge
Reset  input  1  asynchronous, active-low reset
lane_valid  input  LANES  per-lane symbol strobe from decoder
RxParallel_8  input  8*LANES  lane i data on bits [8i+7:8i]
RxDataK  input  LANES  per-lane K flag
ds_data  output  8*LANES  deskewed symbols, same packing as RxParallel_8
ds_k  output  LANES  deskewed K flags
ds_valid  output  1  ds_data/ds_k valid this cycle
aligned  output  1  block in ALIGNED state
skew_err  output  1  one-cycle pulse: search timeout
align_err  output  1  one-cycle pulse: COM missing on some lanes in ALIGNED
ovf_err  output  1  one-cycle pulse: FIFO overflow on any lane

Behaviour:
- Reset (Reset=0, async): all outputs 0; FIFOs empty; FSM=SEARCH; skew counter 0.
- Per-lane FIFO:
  - Write when lane_valid[i]=1.
  - A written entry is readable in the next cycle.
  - Push and pop in the same cycle on a full FIFO is legal.
  - Push on a full FIFO with no pop is an overflow.
- A lane's head "is COM" when its FIFO is non-empty, head K=1 and head data=COM.
- FSM SEARCH:
  - aligned=0, ds_valid=0.
  - Any lane whose head is not COM pops one entry per cycle (discard).
  - Lanes whose head is COM hold.
  - Skew counter increments each cycle in which at least one lane holds COM but not all do; otherwise it resets to 0.
  - All LANES heads COM in the same cycle -> pop all lanes, output that COM column, go to ALIGNED, counter=0.
  - Counter reaches MAX_SKEW -> skew_err pulse, flush all FIFOs, stay in SEARCH, counter=0.
- FSM ALIGNED:
  - aligned=1.
  - All FIFOs non-empty -> pop every lane together and register head symbols onto ds_data/ds_k with ds_valid=1 the next cycle.
  - Any FIFO empty -> no pop, ds_valid=0; ds_data/ds_k hold their last values.
  - Popped column contains COM on some lanes but not all -> align_err pulse with that column's ds_valid, flush all FIFOs, go to SEARCH.
- Latency: a symbol written at cycle t appears on ds_data at t+2 at the earliest.
- Overflow on any lane, any state -> ovf_err pulse, flush all FIFOs, go to SEARCH.
  - Overflow takes priority over skew and alignment checks in the same cycle.
- Flush: empties FIFOs at the clock edge. A lane_valid symbol arriving in the flush cycle is dropped.
- Width rules: skew counter is clog2(MAX_SKEW+1) bits and saturates at MAX_SKEW. FIFO pointers carry one extra wrap bit for full/empty detection.
- LANES=1: the lane aligns on its first COM; align_err is impossible.

Test Plan:
- 4 lanes, zero skew, stream COM then 8'h00..8'h0F on all lanes -> aligned=1 two cycles after COM written; ds_data = same byte on all lanes each cycle, ds_k=4'b1111 on the COM column only.
- Lane 2 delayed 3 cycles, lane 0 delayed 1, MAX_SKEW=5 -> aligns; ds_data columns identical per cycle; no skew_err.
- Lane 3 delayed 6 cycles with MAX_SKEW=5 -> skew_err pulses once, FIFOs flushed, aligned stays 0 until next COM arrives within skew.
- In ALIGNED, corrupt lane 1 COM to 8'hBD K=1 -> align_err pulses with that column, aligned drops the next cycle, realigns on the following all-lane COM.
- In ALIGNED, hold lane_valid[0]=0 for 3 cycles with others active -> ds_valid=0 those cycles, data order preserved; 9 missing cycles with DEPTH=8 -> ovf_err, return to SEARCH.
- Assert Reset low mid-stream -> all outputs 0 immediately (asynchronous), aligned=0; after release, alignment reacquired on next COM.

Source files
------------

// File: rtl/lane_deskew_if.sv
// Receive-side bundle for the multi-lane deskew stage: per-lane decoder
// symbols in, one aligned symbol column plus status pulses out.
interface lane_deskew_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0]   lane_valid;
    logic [8*LANES-1:0] RxParallel_8;
    logic [LANES-1:0]   RxDataK;
    logic [8*LANES-1:0] ds_data;
    logic [LANES-1:0]   ds_k;
    logic               ds_valid;
    logic               aligned;
    logic               skew_err;
    logic               align_err;
    logic               ovf_err;

    // Decoder side / consumer side (drives symbols, observes the column)
    modport master (
        output lane_valid, RxParallel_8, RxDataK,
        input  ds_data, ds_k, ds_valid, aligned, skew_err, align_err, ovf_err
    );

    // Deskew block side
    modport slave (
        input  lane_valid, RxParallel_8, RxDataK,
        output ds_data, ds_k, ds_valid, aligned, skew_err, align_err, ovf_err
    );
endinterface

// File: rtl/lane_deskew.sv
// Multi-lane receive deskew: each lane is buffered in a small FIFO, lanes are
// lined up on a common K28.5 (COM) symbol, then one symbol per lane is popped
// together every cycle that all lanes have data.
module lane_deskew #(
    parameter int         LANES    = 4,
    parameter int         DEPTH    = 8,
    parameter int         MAX_SKEW = 5,
    parameter logic [7:0] COM      = 8'hBC
) (
    input  logic         RxBitCLK_10,
    input  logic         Reset,
    lane_deskew_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_SKEW + 1);

    typedef enum logic {SEARCH, ALIGNED} state_t;

    state_t                   state_q, state_d;
    logic [LANES-1:0][AW:0]   wr_ptr_q, wr_ptr_d;
    logic [LANES-1:0][AW:0]   rd_ptr_q, rd_ptr_d;
    logic [8:0]               mem_q [LANES][DEPTH];
    logic [CW-1:0]            skew_cnt_q, skew_cnt_d;
    logic [8*LANES-1:0]       ds_data_q, ds_data_d;
    logic [LANES-1:0]         ds_k_q, ds_k_d;
    logic                     ds_valid_q, ds_valid_d;
    logic                     skew_err_q, skew_err_d;
    logic                     align_err_q, align_err_d;
    logic                     ovf_err_q, ovf_err_d;

    logic [LANES-1:0]         empty, full, head_k, head_com, pop, push, ovf;
    logic [8*LANES-1:0]       head_data;
    logic                     flush;

    // Per-lane FIFO status and head-of-queue decode
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                       (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            {head_k[i], head_data[8*i +: 8]} = mem_q[i][rd_ptr_q[i][AW-1:0]];
            head_com[i] = !empty[i] && head_k[i] && (head_data[8*i +: 8] == COM);
        end
    end

    // Alignment FSM: pop decisions, output column, error pulses
    always_comb begin
        state_d     = state_q;
        skew_cnt_d  = '0;
        ds_data_d   = ds_data_q;
        ds_k_d      = ds_k_q;
        ds_valid_d  = 1'b0;
        skew_err_d  = 1'b0;
        align_err_d = 1'b0;
        ovf_err_d   = 1'b0;
        pop         = '0;
        flush       = 1'b0;
        case (state_q)
            SEARCH: begin
                if (&head_com) begin
                    pop        = '1;
                    ds_data_d  = head_data;
                    ds_k_d     = head_k;
                    ds_valid_d = 1'b1;
                    state_d    = ALIGNED;
                end else begin
                    // Lanes sitting on COM wait; everything else is discarded.
                    pop = ~empty & ~head_com;
                    if (|head_com) begin
                        // MAX_SKEW partial cycles are tolerated; one more times out.
                        if (skew_cnt_q == CW'(MAX_SKEW)) begin
                            skew_err_d = 1'b1;
                            flush      = 1'b1;
                        end else begin
                            skew_cnt_d = skew_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ALIGNED: begin
                if (!(|empty)) begin
                    pop        = '1;
                    ds_data_d  = head_data;
                    ds_k_d     = head_k;
                    ds_valid_d = 1'b1;
                    if ((|head_com) && !(&head_com)) begin
                        align_err_d = 1'b1;
                        flush       = 1'b1;
                        state_d     = SEARCH;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
        // A push into a full lane that is not popping loses data; this wins
        // over any skew or alignment outcome in the same cycle.
        ovf = bus.lane_valid & full & ~pop;
        if (|ovf) begin
            ovf_err_d   = 1'b1;
            skew_err_d  = 1'b0;
            align_err_d = 1'b0;
            skew_cnt_d  = '0;
            flush       = 1'b1;
            state_d     = SEARCH;
        end
    end

    // FIFO pointer update; a flush empties every lane and drops incoming symbols
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            push[i] = bus.lane_valid[i] && !flush && (!full[i] || pop[i]);
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push[i]};
                rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop[i]};
            end
        end
    end

    // Control and output registers
    always_ff @(posedge RxBitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            state_q     <= SEARCH;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            skew_cnt_q  <= '0;
            ds_data_q   <= '0;
            ds_k_q      <= '0;
            ds_valid_q  <= 1'b0;
            skew_err_q  <= 1'b0;
            align_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            skew_cnt_q  <= skew_cnt_d;
            ds_data_q   <= ds_data_d;
            ds_k_q      <= ds_k_d;
            ds_valid_q  <= ds_valid_d;
            skew_err_q  <= skew_err_d;
            align_err_q <= align_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    // Symbol storage; contents only matter behind the pointers, so no reset
    always_ff @(posedge RxBitCLK_10) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= {bus.RxDataK[i], bus.RxParallel_8[8*i +: 8]};
            end
        end
    end

    assign bus.ds_data   = ds_data_q;
    assign bus.ds_k      = ds_k_q;
    assign bus.ds_valid  = ds_valid_q;
    assign bus.aligned   = (state_q == ALIGNED);
    assign bus.skew_err  = skew_err_q;
    assign bus.align_err = align_err_q;
    assign bus.ovf_err   = ovf_err_q;
endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew: 4 lanes, DEPTH 8, MAX_SKEW 5.
// Lane streams repeat COM followed by 8'h00..8'h0F (period 17); negative
// stream indices are non-COM filler symbols.
module tb_lane_deskew;
    localparam int         LANES    = 4;
    localparam int         DEPTH    = 8;
    localparam int         MAX_SKEW = 5;
    localparam logic [7:0] COMB     = 8'hBC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_deskew_if #(.LANES(LANES)) bus ();

    lane_deskew #(
        .LANES(LANES), .DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW), .COM(COMB)
    ) dut (
        .RxBitCLK_10 (clk),
        .Reset       (rst_n),
        .bus         (bus)
    );

    int errors = 0;
    int checks = 0;
    int n      = 0;
    int dly [LANES];

    function automatic logic [8:0] sym(input int j);
        int m;
        if (j < 0) return 9'h055;
        m = j % 17;
        if (m == 0) return {1'b1, COMB};
        return {1'b0, 8'(m - 1)};
    endfunction

    function automatic logic [31:0] col_d(input int j);
        logic [8:0] s;
        s = sym(j);
        return {4{s[7:0]}};
    endfunction

    function automatic logic [31:0] col_k(input int j);
        logic [8:0] s;
        s = sym(j);
        return s[8] ? 32'hF : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic drive_lane(input int i, input bit v, input int j);
        logic [8:0] s;
        s = sym(j);
        bus.lane_valid[i]           = v;
        bus.RxParallel_8[8*i +: 8]  = v ? s[7:0] : 8'h00;
        bus.RxDataK[i]              = v ? s[8] : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_col(input int j);
        chk("aligned", 32'(bus.aligned), 32'd1);
        chk("ds_valid", 32'(bus.ds_valid), 32'd1);
        chk("ds_data", bus.ds_data, col_d(j));
        chk("ds_k", 32'(bus.ds_k), col_k(j));
    endtask

    task automatic expect_idle();
        chk("aligned", 32'(bus.aligned), 32'd0);
        chk("ds_valid", 32'(bus.ds_valid), 32'd0);
    endtask

    task automatic expect_errs(input bit s, input bit a, input bit o);
        chk("err_pulses", 32'({bus.skew_err, bus.align_err, bus.ovf_err}), 32'({s, a, o}));
    endtask

    task automatic expect_all_zero();
        chk("rst_ds_data", bus.ds_data, 32'h0);
        chk("rst_ds_k", 32'(bus.ds_k), 32'h0);
        expect_idle();
        expect_errs(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.lane_valid   = '0;
        bus.RxParallel_8 = '0;
        bus.RxDataK      = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_all_zero();
        rst_n = 1'b1;
        n     = 0;
    endtask

    initial begin
        // ---- zero skew: COM then 00..0F on all lanes
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c);
            step(); n = c + 1;
            if (n >= 2) expect_col(n - 2); else expect_idle();
            expect_errs(1'b0, 1'b0, 1'b0);
        end

        // ---- lane 0 late by 1, lane 2 late by 3: aligns, no skew_err
        do_reset();
        dly = '{1, 0, 3, 0};
        for (int c = 0; c <= 20; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c - dly[i]);
            step(); n = c + 1;
            if (n >= 5) expect_col(n - 5); else expect_idle();
            expect_errs(1'b0, 1'b0, 1'b0);
        end

        // ---- lane 3 late by 6: search timeout, then realign with lanes in step
        do_reset();
        dly = '{0, 0, 0, 6};
        for (int c = 0; c <= 9; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c - dly[i]);
            step(); n = c + 1;
            expect_idle();
            expect_errs(n == 7, 1'b0, 1'b0);
        end
        for (int c = 0; c <= 9; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c);
            step(); n = c + 1;
            if (n >= 2) expect_col(n - 2); else expect_idle();
            expect_errs(1'b0, 1'b0, 1'b0);
        end

        // ---- corrupted COM on lane 1 (BD, K=1) in the second COM column
        do_reset();
        for (int c = 0; c <= 39; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c);
            if (c == 17) bus.RxParallel_8[15:8] = 8'hBD;
            step(); n = c + 1;
            if (n < 2) begin
                expect_idle();
                expect_errs(1'b0, 1'b0, 1'b0);
            end else if (n <= 18) begin
                expect_col(n - 2);
                expect_errs(1'b0, 1'b0, 1'b0);
            end else if (n == 19) begin
                chk("aerr_aligned", 32'(bus.aligned), 32'd0);
                chk("aerr_ds_valid", 32'(bus.ds_valid), 32'd1);
                chk("aerr_ds_data", bus.ds_data, 32'hBCBC_BDBC);
                chk("aerr_ds_k", 32'(bus.ds_k), 32'hF);
                expect_errs(1'b0, 1'b1, 1'b0);
            end else if (n <= 35) begin
                expect_idle();
                expect_errs(1'b0, 1'b0, 1'b0);
            end else begin
                expect_col(n - 2);
                expect_errs(1'b0, 1'b0, 1'b0);
            end
        end

        // ---- lane 0 silent for 3 cycles: stalls, order preserved
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            for (int i = 1; i < LANES; i++) drive_lane(i, 1'b1, c);
            drive_lane(0, !(c >= 5 && c <= 7), (c < 5) ? c : c - 3);
            step(); n = c + 1;
            if (n < 2) expect_idle();
            else if (n <= 6) expect_col(n - 2);
            else if (n <= 9) begin
                chk("stall_aligned", 32'(bus.aligned), 32'd1);
                chk("stall_ds_valid", 32'(bus.ds_valid), 32'd0);
                chk("stall_hold", bus.ds_data, col_d(4));
            end else expect_col(n - 5);
            expect_errs(1'b0, 1'b0, 1'b0);
        end

        // ---- lane 0 silent for 9 cycles: other lanes overflow
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            for (int i = 1; i < LANES; i++) drive_lane(i, 1'b1, c);
            drive_lane(0, !(c >= 5 && c <= 13), (c < 5) ? c : c - 9);
            step(); n = c + 1;
            if (n < 2) begin
                expect_idle();
                expect_errs(1'b0, 1'b0, 1'b0);
            end else if (n <= 6) begin
                expect_col(n - 2);
                expect_errs(1'b0, 1'b0, 1'b0);
            end else if (n <= 13) begin
                chk("ovf_wait_aligned", 32'(bus.aligned), 32'd1);
                chk("ovf_wait_ds_valid", 32'(bus.ds_valid), 32'd0);
                expect_errs(1'b0, 1'b0, 1'b0);
            end else begin
                expect_idle();
                expect_errs(1'b0, 1'b0, n == 14);
            end
        end

        // ---- asynchronous reset in the middle of an aligned stream
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c);
            step(); n = c + 1;
            if (n >= 2) expect_col(n - 2); else expect_idle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_all_zero();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            for (int i = 0; i < LANES; i++) drive_lane(i, 1'b1, c);
            step(); n = c + 1;
            if (n >= 2) expect_col(n - 2); else expect_idle();
            expect_errs(1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
